// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: steps a 4-input gate through all 16 vectors and captures its response.
// Optional build macro TT_COMPARE_EN adds a registered compare of the captured table against EXPECTED_TT.
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED_TT   = 16'hF4E7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        dut_out,
    output logic [3:0]  dut_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt_word,
    output logic        match
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_idx, w_idx_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_dut_in, w_dut_in_nxt;
    logic [15:0] r_tt, w_tt_nxt;
    logic        r_busy, r_done;
    logic        w_busy_nxt, w_done_nxt;
    logic        w_start_ok;

    assign w_start_ok = start & ~abort;

    // Next-state and datapath update; abort wins over any sample write in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_dut_in_nxt = r_dut_in;
        w_tt_nxt     = r_tt;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt  = ST_SETTLE;
                    w_idx_nxt    = 4'd0;
                    w_cnt_nxt    = 4'd0;
                    w_dut_in_nxt = 4'd0;
                    w_tt_nxt     = 16'h0000;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_state_nxt  = ST_IDLE;
                    w_dut_in_nxt = 4'd0;
                    w_cnt_nxt    = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt == SETTLE_LAST) begin
                        w_state_nxt = ST_SAMPLE;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    w_state_nxt  = ST_IDLE;
                    w_dut_in_nxt = 4'd0;
                    w_cnt_nxt    = 4'd0;
                end else begin
                    w_tt_nxt[r_idx] = dut_out;
                    if (r_idx == 4'd15) begin
                        w_state_nxt  = ST_DONE;
                        w_dut_in_nxt = 4'd0;
                    end else begin
                        w_state_nxt  = ST_SETTLE;
                        w_idx_nxt    = r_idx + 4'd1;
                        w_dut_in_nxt = r_idx + 4'd1;
                        w_cnt_nxt    = 4'd0;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt  = ST_IDLE;
                w_dut_in_nxt = 4'd0;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_dut_in_nxt = 4'd0;
            end
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
    assign w_done_nxt = (w_state_nxt == ST_DONE);

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= 4'd0;
            r_cnt    <= 4'd0;
            r_dut_in <= 4'd0;
            r_tt     <= 16'h0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dut_in <= w_dut_in_nxt;
            r_tt     <= w_tt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

`ifdef TT_COMPARE_EN
    logic r_match, w_match_nxt;

    // Match is cleared on an accepted start and captured from the final table on entry to DONE.
    always_comb begin
        w_match_nxt = r_match;
        if ((r_state == ST_IDLE) && (w_state_nxt == ST_SETTLE)) begin
            w_match_nxt = 1'b0;
        end else if ((r_state == ST_SAMPLE) && (w_state_nxt == ST_DONE)) begin
            w_match_nxt = (w_tt_nxt == EXPECTED_TT);
        end else begin
            w_match_nxt = r_match;
        end
    end

    // Match register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_match <= 1'b0;
        end else begin
            r_match <= w_match_nxt;
        end
    end

    assign match = r_match;
`else
    // Reference table only feeds the optional comparator; reduced to a constant here.
    logic w_unused_cfg;
    assign w_unused_cfg = ^EXPECTED_TT;
    assign match        = 1'b0;
`endif

    assign dut_in  = r_dut_in;
    assign busy    = r_busy;
    assign done    = r_done;
    assign tt_word = r_tt;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Self-checking bench for tt_sweep_ctrl: default-parameter instance driving an 0xF4E7 gate model,
// plus a SETTLE_CYCLES=1 instance driving a constant-0 gate; done results checked via scoreboards.
module tb_tt_sweep_ctrl;

`ifdef TT_COMPARE_EN
    localparam logic CMP_ON = 1'b1;
`else
    localparam logic CMP_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] tt;
        logic        m;
        int          done_edge;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, abort0, dut_out0, busy0, done0, match0;
    logic [3:0]  dut_in0;
    logic [15:0] tt_word0;
    logic        start1, abort1, dut_out1, busy1, done1, match1;
    logic [3:0]  dut_in1;
    logic [15:0] tt_word1;
    logic [15:0] model0 = 16'hF4E7;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign dut_out0 = model0[dut_in0];
    assign dut_out1 = 1'b0;

    tt_sweep_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .dut_out(dut_out0),
        .dut_in(dut_in0), .busy(busy0), .done(done0), .tt_word(tt_word0), .match(match0)
    );

    tt_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .dut_out(dut_out1),
        .dut_in(dut_in1), .busy(busy1), .done(done1), .tt_word(tt_word1), .match(match1)
    );

    // Scoreboard: every done pulse must match the oldest pending expectation for its instance.
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL done0_unexpected: done pulse at edge %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = q0.pop_front();
                if (tt_word0 !== e.tt || match0 !== e.m || cyc != e.done_edge) begin
                    errors++;
                    $display("FAIL done0_result: tt=%h match=%b edge=%0d, expected tt=%h match=%b edge=%0d",
                             tt_word0, match0, cyc, e.tt, e.m, e.done_edge);
                end
            end
        end
        if (done1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL done1_unexpected: done pulse at edge %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                if (tt_word1 !== e.tt || match1 !== e.m || cyc != e.done_edge) begin
                    errors++;
                    $display("FAIL done1_result: tt=%h match=%b edge=%0d, expected tt=%h match=%b edge=%0d",
                             tt_word1, match1, cyc, e.tt, e.m, e.done_edge);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        start0 = 1'b0; abort0 = 1'b0;
        start1 = 1'b0; abort1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dut_in0, busy0, done0, tt_word0, match0, dut_in1, busy1, done1, tt_word1, match1} !== 46'd0) begin
            errors++;
            $display("FAIL reset_outputs: dut0 in=%h b=%b d=%b tt=%h m=%b dut1 in=%h b=%b d=%b tt=%h m=%b, expected all 0",
                     dut_in0, busy0, done0, tt_word0, match0, dut_in1, busy1, done1, tt_word1, match1);
        end
        rst_n  = 1'b1;
        start0 = 1'b1;
        q0.push_back('{tt: 16'hF4E7, m: CMP_ON, done_edge: cyc + 1 + 48});
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL first_start: busy=%b, expected 1", busy0);
        end
        for (int n = 0; n < 100 && q0.size() != 0; n++) @(negedge clk);
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL first_sweep_timeout: pending=%0d, expected 0", q0.size());
        end
    endtask

    task automatic test_full_sweep();
        @(negedge clk);
        start0 = 1'b1;
        q0.push_back('{tt: 16'hF4E7, m: CMP_ON, done_edge: cyc + 1 + 48});
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 48; k++) begin
            checks++;
            if (dut_in0 !== 4'(k / 3) || busy0 !== 1'b1) begin
                errors++;
                $display("FAIL sweep_vector k=%0d: dut_in=%0d busy=%b, expected dut_in=%0d busy=1",
                         k, dut_in0, busy0, k / 3);
            end
            @(negedge clk);
        end
        checks++;
        if (busy0 !== 1'b0 || dut_in0 !== 4'd0) begin
            errors++;
            $display("FAIL sweep_done_state: busy=%b dut_in=%0d, expected busy=0 dut_in=0", busy0, dut_in0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tt_word0 !== 16'hF4E7 || match0 !== CMP_ON || done0 !== 1'b0 || q0.size() != 0) begin
            errors++;
            $display("FAIL sweep_hold: tt=%h match=%b done=%b pending=%0d, expected tt=f4e7 match=%b done=0 pending=0",
                     tt_word0, match0, done0, q0.size(), CMP_ON);
        end
    endtask

    task automatic test_settle1_zero();
        @(negedge clk);
        start1 = 1'b1;
        q1.push_back('{tt: 16'h0000, m: 1'b0, done_edge: cyc + 1 + 32});
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (dut_in1 !== 4'(k / 2) || busy1 !== 1'b1) begin
                errors++;
                $display("FAIL settle1_vector k=%0d: dut_in=%0d busy=%b, expected dut_in=%0d busy=1",
                         k, dut_in1, busy1, k / 2);
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q1.size() != 0 || busy1 !== 1'b0 || dut_in1 !== 4'd0) begin
            errors++;
            $display("FAIL settle1_end: pending=%0d busy=%b dut_in=%0d, expected 0 0 0", q1.size(), busy1, dut_in1);
        end
    endtask

    task automatic test_abort();
        int offs[2];
        offs = '{15, 17};
        for (int a = 0; a < 2; a++) begin
            @(negedge clk);
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
            repeat (offs[a]) @(negedge clk);
            checks++;
            if (dut_in0 !== 4'd5) begin
                errors++;
                $display("FAIL abort_setup offset=%0d: dut_in=%0d, expected 5", offs[a], dut_in0);
            end
            abort0 = 1'b1;
            @(negedge clk);
            abort0 = 1'b0;
            checks++;
            if (busy0 !== 1'b0 || dut_in0 !== 4'd0 || tt_word0 !== 16'h0007 || match0 !== 1'b0) begin
                errors++;
                $display("FAIL abort_next offset=%0d: busy=%b dut_in=%0d tt=%h match=%b, expected 0 0 0007 0",
                         offs[a], busy0, dut_in0, tt_word0, match0);
            end
            repeat (60) @(negedge clk);
            checks++;
            if (busy0 !== 1'b0 || tt_word0 !== 16'h0007) begin
                errors++;
                $display("FAIL abort_hold offset=%0d: busy=%b tt=%h, expected busy=0 tt=0007", offs[a], busy0, tt_word0);
            end
        end
    endtask

    task automatic test_restart_ignored();
        @(negedge clk);
        start0 = 1'b1;
        q0.push_back('{tt: 16'hF4E7, m: CMP_ON, done_edge: cyc + 1 + 48});
        @(negedge clk);
        for (int k = 0; k < 48; k++) begin
            start0 = (k == 2 || k == 19) ? 1'b1 : 1'b0;
            checks++;
            if (dut_in0 !== 4'(k / 3) || busy0 !== 1'b1) begin
                errors++;
                $display("FAIL restart_vector k=%0d: dut_in=%0d busy=%b, expected dut_in=%0d busy=1",
                         k, dut_in0, busy0, k / 3);
            end
            @(negedge clk);
        end
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%b, expected 0", busy0);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (q0.size() != 0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL restart_end: pending=%0d busy=%b, expected 0 0", q0.size(), busy0);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (27) @(negedge clk);
        checks++;
        if (dut_in0 !== 4'd9) begin
            errors++;
            $display("FAIL reset_mid_setup: dut_in=%0d, expected 9", dut_in0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({dut_in0, busy0, done0, tt_word0, match0} !== 23'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: dut_in=%h busy=%b done=%b tt=%h match=%b, expected all 0",
                     dut_in0, busy0, done0, tt_word0, match0);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || tt_word0 !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_idle: busy=%b tt=%h, expected 0 0000", busy0, tt_word0);
        end
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        start0 = 1'b1;
        abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        abort0 = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || tt_word0 !== 16'hF4E7) begin
            errors++;
            $display("FAIL start_abort_idle: busy=%b tt=%h, expected busy=0 tt=f4e7", busy0, tt_word0);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || tt_word0 !== 16'hF4E7 || match0 !== CMP_ON) begin
            errors++;
            $display("FAIL start_abort_hold: busy=%b tt=%h match=%b, expected 0 f4e7 %b", busy0, tt_word0, match0, CMP_ON);
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_settle1_zero();
        test_abort();
        test_restart_ignored();
        test_reset_mid();
        test_full_sweep();
        test_start_abort_idle();
        repeat (2) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending0=%0d pending1=%0d, expected 0 0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, giving cycles each input vector is held before sampling; legal range 1..15.
REQ-002 SHALL have parameter EXPECTED_TT, default 16'hF4E7, giving the reference 4-input truth table.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous reset, active-low.
REQ-005 SHALL have port start  input  1  sweep request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancels the sweep in progress.
REQ-007 SHALL have port dut_out  input  1  combinational response of the gate under test.
REQ-008 SHALL have port dut_in  output  4  registered input vector driven to the gate under test.
REQ-009 SHALL have port busy  output  1  high in SETTLE and SAMPLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port tt_word  output  16  captured truth table; bit k holds dut_out for dut_in==k.
REQ-012 SHALL have port match  output  1  comparison result (see Configuration).

Function
REQ-013 SHALL implement the FSM states IDLE, SETTLE, SAMPLE and DONE, with a 4-bit vector index and a 4-bit settle counter.
REQ-014 IDLE with start=1 and abort=0 SHALL clear tt_word, set index=0, dut_in=0 and counter=0, and go to SETTLE.
REQ-015 SETTLE SHALL increment the counter each cycle and go to SAMPLE in the cycle after counter==SETTLE_CYCLES-1.
REQ-016 SAMPLE SHALL write dut_out into tt_word[index]; if index==15, go to DONE; otherwise index and dut_in advance by 1, counter clears and the FSM returns to SETTLE.
REQ-017 DONE SHALL assert done for exactly one cycle, then return to IDLE; dut_in SHALL return to 0.
REQ-018 Latency: done SHALL be high in the cycle beginning 16*(SETTLE_CYCLES+1) rising edges after the edge that sampled start (48 for the default).
REQ-019 dut_in SHALL change only on entry to a vector and SHALL stay stable for SETTLE_CYCLES+1 cycles per vector.
REQ-020 start while busy or in DONE SHALL be ignored; no queuing.
REQ-021 abort=1 in SETTLE or SAMPLE SHALL force IDLE on the next edge with dut_in=0 and no done pulse.
REQ-022 After an abort, tt_word SHALL keep the partially captured bits, and the SAMPLE write in the abort cycle SHALL be suppressed.
REQ-023 In IDLE, abort=1 SHALL take priority over start: the FSM remains in IDLE.
REQ-024 In DONE, abort SHALL have no effect.
REQ-025 tt_word SHALL hold its value from DONE until the next accepted start.
REQ-026 The index SHALL NOT wrap: a sweep always ends after vector 15.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force IDLE.
REQ-028 rst_n=0 at a rising edge SHALL clear dut_in, busy, done, tt_word, match, the index and the counter to 0.
REQ-029 Reset mid-sweep SHALL abandon the sweep with no done pulse.
REQ-030 The first start is accepted on the first edge with rst_n=1.

Configuration
REQ-031 Macro TT_COMPARE_EN SHALL control the comparison feature.
REQ-032 With TT_COMPARE_EN defined, on entry to DONE match SHALL be registered as (final tt_word == EXPECTED_TT).
REQ-033 With TT_COMPARE_EN defined, match SHALL be held until the next accepted start or reset, and cleared at an accepted start.
REQ-034 Without TT_COMPARE_EN, no comparator SHALL be built and match SHALL be tied to constant 0.
REQ-035 All other behaviour SHALL be identical with and without TT_COMPARE_EN.

Verification
REQ-036 Default parameters, behavioural 0xF4E7 model as the gate under test, start pulse: done at edge +48, tt_word=0xF4E7, match=1 (macro on) or 0 (macro off).
REQ-037 Constant-0 gate under test, SETTLE_CYCLES=1: done at edge +32, tt_word=0x0000, match=0; dut_in steps 0..15, each held exactly 2 cycles.
REQ-038 abort asserted while dut_in==5 in SETTLE: busy=0 and dut_in=0 next cycle, no done, tt_word[15:5]=0 with bits 4..0 captured.
REQ-039 start re-pulsed at cycles 3 and 20 of a sweep: ignored, and done still occurs exactly once at edge +48.
REQ-040 rst_n=0 for one edge at vector 9: all outputs 0, FSM in IDLE, no done; a new start gives a full correct sweep.
REQ-041 start and abort high together in IDLE: busy stays 0, tt_word unchanged.
